uart_rx_deframer: RTL and testbench

Serial receive stage of the UART: consumes the uart_rx line, oversamples it at 16x the baud rate, deframes start/data/parity/stop bits, and presents one received byte in a single-entry holding register. It drives the receive-side interrupt flags (ctrl_rif, ctrl_pif, ctrl_fif, ctrl_oif) consumed by the interrupt logic. The APB register block supplies configuration and read/clear strobes.

---
 rtl/uart_rx_deframer.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 16x oversampled start/data/parity/stop recovery feeding
// a single-entry holding register with sticky parity/framing/overrun flags.
module uart_rx_deframer #(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned OVS   = 16
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             cfg_en,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_dls,
    input  logic             cfg_pen,
    input  logic             cfg_eps,
    input  logic             cfg_stb,
    input  logic             uart_rx,
    input  logic             rx_rd,
    input  logic             clr_pif,
    input  logic             clr_fif,
    input  logic             clr_oif,
    output logic [7:0]       rx_data,
    output logic             rx_full,
    output logic             ctrl_rif,
    output logic             ctrl_pif,
    output logic             ctrl_fif,
    output logic             ctrl_oif,
    output logic             busy
);

    localparam int unsigned SMP_W = $clog2(OVS);
    localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(OVS / 2 - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_e;

    state_e             state_q, state_d;
    logic               rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [SMP_W-1:0]   smp_q, smp_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic [1:0]         dls_q, dls_d;
    logic               pen_q, pen_d, eps_q, eps_d, stb_q, stb_d;
    logic               perr_q, perr_d, ferr_q, ferr_d;
    logic               commit_q, commit_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_full_q, rx_full_d;
    logic               pif_q, pif_d, fif_q, fif_d, oif_q, oif_d;

    logic [DIV_W-1:0]   div_last;
    logic               tick, sample;

    always_comb begin
        rx_s1_d   = uart_rx;
        rx_s2_d   = rx_s1_q;
        rx_prev_d = rx_s2_q;
        state_d   = state_q;
        smp_d     = smp_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        dls_d     = dls_q;
        pen_d     = pen_q;
        eps_d     = eps_q;
        stb_d     = stb_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        commit_d  = 1'b0;

        // A zero divisor is treated as one: a tick on every enabled cycle.
        div_last  = (cfg_div == '0) ? '0 : cfg_div - DIV_W'(1);
        tick      = cfg_en && (div_cnt_q >= div_last);
        div_cnt_d = (!cfg_en || tick) ? '0 : div_cnt_q + DIV_W'(1);
        sample    = tick && (smp_q == SMP_MID);
        if (tick) begin
            smp_d = (smp_q == SMP_LAST) ? '0 : smp_q + SMP_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (cfg_en && rx_prev_q && !rx_s2_q) begin
                    state_d   = START;
                    smp_d     = '0;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                    dls_d     = cfg_dls;
                    pen_d     = cfg_pen;
                    eps_d     = cfg_eps;
                    stb_d     = cfg_stb;
                end
            end
            START: begin
                if (sample) state_d = rx_s2_q ? IDLE : DATA;
            end
            DATA: begin
                if (sample) begin
                    shift_d[bit_cnt_q] = rx_s2_q;
                    if (bit_cnt_q == {1'b0, dls_q} + 3'd4) begin
                        state_d = pen_q ? PARITY : STOP1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (sample) begin
                    // Upper unused data bits are zero, so reducing all 8 is safe.
                    perr_d  = ((^shift_q) ^ rx_s2_q) == eps_q;
                    state_d = STOP1;
                end
            end
            STOP1: begin
                if (sample) begin
                    if (!rx_s2_q) ferr_d = 1'b1;
                    if (stb_q) begin
                        state_d = STOP2;
                    end else begin
                        state_d  = IDLE;
                        commit_d = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (sample) begin
                    if (!rx_s2_q) ferr_d = 1'b1;
                    state_d  = IDLE;
                    commit_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!cfg_en) begin
            state_d   = IDLE;
            smp_d     = '0;
            bit_cnt_d = '0;
        end

        rx_data_d = rx_data_q;
        rx_full_d = rx_full_q & ~rx_rd;
        pif_d     = pif_q & ~clr_pif;
        fif_d     = fif_q & ~clr_fif;
        oif_d     = oif_q & ~clr_oif;
        // Commit reads the frame registers before any new start clears them.
        if (commit_q) begin
            if (!rx_full_q || rx_rd) begin
                rx_data_d = shift_q;
                rx_full_d = 1'b1;
                pif_d     = pif_d | perr_q;
                fif_d     = fif_d | ferr_q;
            end else begin
                oif_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q   <= IDLE;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            div_cnt_q <= '0;
            smp_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            dls_q     <= '0;
            pen_q     <= 1'b0;
            eps_q     <= 1'b0;
            stb_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            commit_q  <= 1'b0;
            rx_data_q <= '0;
            rx_full_q <= 1'b0;
            pif_q     <= 1'b0;
            fif_q     <= 1'b0;
            oif_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_s1_q   <= rx_s1_d;
            rx_s2_q   <= rx_s2_d;
            rx_prev_q <= rx_prev_d;
            div_cnt_q <= div_cnt_d;
            smp_q     <= smp_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            dls_q     <= dls_d;
            pen_q     <= pen_d;
            eps_q     <= eps_d;
            stb_q     <= stb_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            commit_q  <= commit_d;
            rx_data_q <= rx_data_d;
            rx_full_q <= rx_full_d;
            pif_q     <= pif_d;
            fif_q     <= fif_d;
            oif_q     <= oif_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_full  = rx_full_q;
    assign ctrl_rif = rx_full_q;
    assign ctrl_pif = pif_q;
    assign ctrl_fif = fif_q;
    assign ctrl_oif = oif_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: directed scenarios then random frames checked
// against a frame-level model of the holding register and flags.
module tb_uart_rx_deframer;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic        cfg_en;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_dls;
    logic        cfg_pen, cfg_eps, cfg_stb;
    logic        uart_rx, rx_rd, clr_pif, clr_fif, clr_oif;
    logic [7:0]  rx_data;
    logic        rx_full, ctrl_rif, ctrl_pif, ctrl_fif, ctrl_oif, busy;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0]  m_data;
    bit          m_full, m_pif, m_fif, m_oif;

    uart_rx_deframer #(.DIV_W(16), .OVS(16)) dut (
        .pclk(pclk), .preset_n(preset_n), .cfg_en(cfg_en), .cfg_div(cfg_div),
        .cfg_dls(cfg_dls), .cfg_pen(cfg_pen), .cfg_eps(cfg_eps), .cfg_stb(cfg_stb),
        .uart_rx(uart_rx), .rx_rd(rx_rd), .clr_pif(clr_pif), .clr_fif(clr_fif),
        .clr_oif(clr_oif), .rx_data(rx_data), .rx_full(rx_full), .ctrl_rif(ctrl_rif),
        .ctrl_pif(ctrl_pif), .ctrl_fif(ctrl_fif), .ctrl_oif(ctrl_oif), .busy(busy)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_data"}, 16'(rx_data), 16'(m_data));
        check({tag, "_full"}, 16'(rx_full), 16'(m_full));
        check({tag, "_rif"},  16'(ctrl_rif), 16'(m_full));
        check({tag, "_pif"},  16'(ctrl_pif), 16'(m_pif));
        check({tag, "_fif"},  16'(ctrl_fif), 16'(m_fif));
        check({tag, "_oif"},  16'(ctrl_oif), 16'(m_oif));
        check({tag, "_busy"}, 16'(busy), 16'd0);
    endtask

    task automatic model_reset();
        m_data = '0; m_full = 0; m_pif = 0; m_fif = 0; m_oif = 0;
    endtask

    task automatic model_commit(input logic [7:0] d, input bit perr, input bit ferr, input bit rd_same);
        if (!m_full || rd_same) begin
            m_data = d; m_full = 1;
            m_pif = m_pif | perr;
            m_fif = m_fif | ferr;
        end else begin
            m_oif = 1;
        end
    endtask

    task automatic rd_pulse();
        rx_rd = 1; step(1); rx_rd = 0;
        m_full = 0;
    endtask

    task automatic clr_all();
        clr_pif = 1; clr_fif = 1; clr_oif = 1; step(1);
        clr_pif = 0; clr_fif = 0; clr_oif = 0;
        m_pif = 0; m_fif = 0; m_oif = 0;
    endtask

    // Plays n bit-levels from v, each bitlen cycles, then two idle-high bits.
    task automatic send_seq(input int unsigned n, input logic [15:0] v, input int unsigned bitlen,
                            input int unsigned rd_at, input int unsigned stop_after,
                            output int unsigned lat);
        int unsigned total;
        logic prev_full;
        total = (n + 2) * bitlen;
        lat = 0;
        prev_full = rx_full;
        for (int unsigned c = 0; c < total; c++) begin
            if (stop_after != 0 && c == stop_after) break;
            uart_rx = (c / bitlen < n) ? v[c / bitlen] : 1'b1;
            rx_rd = (rd_at != 0 && c == rd_at - 1);
            @(posedge pclk);
            #1;
            if (lat == 0 && rx_full && !prev_full) lat = c + 1;
            prev_full = rx_full;
        end
        rx_rd = 0;
    endtask

    function automatic logic [7:0] dmask(input int unsigned nb);
        logic [15:0] w;
        w = (16'd1 << nb) - 16'd1;
        return w[7:0];
    endfunction

    task automatic build(input logic [7:0] d, input int unsigned nb, input bit pen, input bit pbit,
                         input bit s1, input bit s2, input bit stb,
                         output logic [15:0] v, output int unsigned n);
        int unsigned k;
        v = '1;
        v[0] = 1'b0;
        for (int unsigned i = 0; i < nb; i++) v[1 + i] = d[i];
        k = 1 + nb;
        if (pen) begin v[k] = pbit; k++; end
        v[k] = s1; k++;
        if (stb) begin v[k] = s2; k++; end
        n = k;
    endtask

    task automatic do_frame(input logic [7:0] d, input bit pbad, input bit s1, input bit s2,
                            input int unsigned rd_at, input int unsigned stop_after,
                            output int unsigned lat);
        int unsigned nb, bitlen, n;
        logic [7:0] dm;
        logic [15:0] v;
        bit good_p;
        nb = 32'(cfg_dls) + 5;
        bitlen = 16 * ((cfg_div == 0) ? 1 : 32'(cfg_div));
        dm = d & dmask(nb);
        good_p = (^dm) ^ !cfg_eps;
        build(d, nb, cfg_pen, good_p ^ pbad, s1, s2, cfg_stb, v, n);
        send_seq(n, v, bitlen, rd_at, stop_after, lat);
        if (stop_after == 0)
            model_commit(dm, cfg_pen && pbad, !s1 || (cfg_stb && !s2), rd_at != 0);
    endtask

    task automatic set_cfg(input logic [15:0] div, input logic [1:0] dls, input bit pen,
                           input bit eps, input bit stb);
        cfg_div = div; cfg_dls = dls; cfg_pen = pen; cfg_eps = eps; cfg_stb = stb;
    endtask

    initial begin
        int unsigned lat, lat11;
        bit seen_busy;
        logic [7:0] rd;
        logic [15:0] rdiv;

        preset_n = 0; cfg_en = 0; uart_rx = 1; rx_rd = 0;
        clr_pif = 0; clr_fif = 0; clr_oif = 0;
        set_cfg(16'd1, 2'b11, 0, 0, 0);
        model_reset();
        step(3);
        check_all("reset");
        preset_n = 1; cfg_en = 1;
        step(3);

        // 8N1 0xA5, latency from start edge to rx_full
        do_frame(8'hA5, 0, 1, 1, 0, 0, lat);
        check("a5_latency_ok", 16'(lat >= 148 && lat <= 162), 16'd1);
        check_all("a5");

        // 7E1 with wrong parity bit
        rd_pulse();
        set_cfg(16'd1, 2'b10, 1, 1, 0);
        do_frame(8'h35, 1, 1, 1, 0, 0, lat);
        check_all("par_err");
        clr_pif = 1; step(1); clr_pif = 0; m_pif = 0;
        check_all("par_clr");

        // 8N2 with bad second stop bit, then a break
        rd_pulse();
        set_cfg(16'd1, 2'b11, 0, 0, 1);
        do_frame(8'hC3, 0, 1, 0, 0, 0, lat);
        check_all("stop2_err");
        clr_all();
        rd_pulse();
        send_seq(12, 16'h0000, 16, 0, 0, lat);
        model_commit(8'h00, 0, 1, 0);
        step(40);
        check_all("break");

        // overrun, then read on the exact commit cycle
        clr_all();
        rd_pulse();
        set_cfg(16'd1, 2'b11, 0, 0, 0);
        do_frame(8'h11, 0, 1, 1, 0, 0, lat11);
        do_frame(8'h22, 0, 1, 1, 0, 0, lat);
        check_all("overrun");
        clr_all();
        rd_pulse();
        do_frame(8'h11, 0, 1, 1, 0, 0, lat);
        do_frame(8'h22, 0, 1, 1, lat11, 0, lat);
        check_all("rd_on_commit");

        // short low glitch: false start
        rd_pulse();
        seen_busy = 0;
        uart_rx = 0;
        for (int unsigned i = 0; i < 4; i++) begin step(1); seen_busy |= busy; end
        uart_rx = 1;
        for (int unsigned i = 0; i < 30; i++) begin step(1); seen_busy |= busy; end
        check("glitch_busy_seen", 16'(seen_busy), 16'd1);
        check_all("glitch");

        // receiver disabled mid-frame: FSM idles, holding state kept
        do_frame(8'h77, 0, 1, 1, 0, 0, lat);
        do_frame(8'h5A, 0, 1, 1, 0, 60, lat);
        uart_rx = 1; cfg_en = 0;
        step(1);
        check_all("disable");
        cfg_en = 1;
        step(5);

        // reset in the middle of data bits, then a clean frame
        do_frame(8'h5A, 0, 1, 1, 0, 50, lat);
        preset_n = 0;
        #1;
        model_reset();
        check_all("reset_mid");
        uart_rx = 1;
        step(3);
        preset_n = 1;
        step(3);
        do_frame(8'h5A, 0, 1, 1, 0, 0, lat);
        check_all("after_reset");

        // random frames and configurations
        for (int unsigned it = 0; it < 12; it++) begin
            if ($urandom_range(0, 1) == 1) rd_pulse();
            if ($urandom_range(0, 2) == 0) clr_all();
            rdiv = 16'($urandom_range(0, 3));
            set_cfg(rdiv, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            rd = 8'($urandom);
            do_frame(rd, $urandom_range(0, 3) == 0, $urandom_range(0, 5) != 0,
                     $urandom_range(0, 5) != 0, 0, 0, lat);
            check_all($sformatf("rand%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
